aes_ct_result_fifo: RTL and testbench
=====================================

// Module: aes_ct_result_fifo
// PURPOSE
//  - Capture stage directly downstream of the AES core in the eFPGA AES peripheral.
//  - Latches each 128-bit ciphertext on the rising edge of the core's ct_valid level.
//  - Queues captured blocks in a small FIFO, so software can run back-to-back
//    encryptions without losing results.
//  - Presents the head entry as four 32-bit words to the AXI-Lite register read mux.
//    Software pops an entry after reading it.
// PARAMETERS
//  DEPTH      4    number of 128-bit entries; power of two, >= 2
//  CNT_W      $clog2(DEPTH)+1   width of occupancy count (derived, not overridden)
// PORTS
//  clk_i          in   1      system clock
//  rst_ni         in   1      asynchronous active-low reset
//  ct_i           in   128    ciphertext from AES core; stable while ct_valid_i high
//  ct_valid_i     in   1      AES core result-valid level (held high until next start)
//  clear_i        in   1      synchronous flush pulse from register write side
//  pop_i          in   1      single-cycle pulse: discard head entry
//  rd_word_sel_i  in   2      head word select: 0=ct[31:0] .. 3=ct[127:96]
//  rd_data_o      out  32     selected 32-bit word of head entry
//  count_o        out  CNT_W  number of valid entries (0..DEPTH)
//  empty_o        out  1      count_o == 0
//  full_o         out  1      count_o == DEPTH
//  overflow_o     out  1      sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async assert, sync release by clk_i):
//    - wr_ptr, rd_ptr, count = 0; overflow_o = 0; valid_q (ct_valid_i delayed) = 0.
//    - Storage array is not reset.
//    - Output values: empty_o=1, full_o=0, rd_data_o=0.
//  - Edge detect:
//    - push_req = ct_valid_i & ~valid_q; valid_q <= ct_valid_i every cycle.
//    - A level held high for N cycles yields exactly one push_req.
//    - If ct_valid_i is already high when reset releases, one capture occurs on the
//      first clock.
//  - Push: on push_req & ~full, ct_i is written at wr_ptr, wr_ptr advances, count increments.
//  - Drop: on push_req & full & ~pop_i, data is discarded and overflow_o is set.
//  - Pop: on pop_i & ~empty, rd_ptr advances and count decrements.
//    - pop_i while empty is ignored, with no error flag.
//  - Simultaneous push_req and pop_i:
//    - Not empty: both are performed and count is unchanged. This holds when full,
//      so there is no drop and overflow is unchanged.
//    - Empty: the pop is ignored and the push is accepted, so count becomes 1.
//  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally.
//  - clear_i (synchronous, highest priority):
//    - wr_ptr, rd_ptr, count and overflow are zeroed.
//    - Any push or pop in the same cycle is discarded.
//    - valid_q still updates, so a level that is high during the clear is not re-captured.
//  - Read path (combinational):
//    - rd_data_o = mem[rd_ptr][32*rd_word_sel_i +: 32] when ~empty_o, else 32'h0.
//  - Latency: a block captured in cycle N is visible on rd_data_o and count_o in cycle N+1.
//  - Status outputs are registered or derived from registered count; there is no
//    combinational path from ct_valid_i to any output.
//  - Reset mid-operation: all queued entries are lost and overflow is cleared, with
//    no partial state retained.
// TESTING
//  - Reset: rst_ni low, then high -> empty_o=1, full_o=0, count_o=0, overflow_o=0,
//    rd_data_o=0.
//  - Single capture:
//    - Stimulus: ct_i=128'h00112233_44556677_8899AABB_CCDDEEFF, ct_valid_i high for 5 cycles.
//    - Result: count_o=1 exactly; sel 0..3 read CCDDEEFF, 8899AABB, 44556677, 00112233.
//  - Fill and overflow: 5 valid pulses with ct_i=1..5, DEPTH=4 -> full_o=1, overflow_o=1.
//    Popping 4x reads 1,2,3,4, then empty_o=1.
//  - Full with simultaneous push and pop: FIFO full of 1..4; valid edge with ct_i=9
//    coincides with pop_i -> count_o stays 4, overflow_o=0, heads read 2,3,4,9.
//  - Empty edge cases:
//    - pop_i alone while empty: count_o stays 0.
//    - pop_i together with a valid edge (ct_i=7) while empty: count_o=1, head=7.
//  - Clear and wrap:
//    - 3 pushes, then clear_i while ct_valid_i is still high: count_o=0, overflow_o=0,
//      and no re-capture.
//    - Then 10 push/pop pairs: data order is preserved across pointer wrap.

Source files
------------

// File: rtl/aes_ct_result_fifo.sv
// Ciphertext capture FIFO behind the AES core: captures one 128-bit block per
// rising edge of ct_valid_i and presents the head entry as 32-bit words to the register read mux.
module aes_ct_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [127:0]              ct_i,
    input  logic                      ct_valid_i,
    input  logic                      clear_i,
    input  logic                      pop_i,
    input  logic [1:0]                rd_word_sel_i,
    output logic [31:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CT_W  = 128;

    logic [CT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             overflow_q;

    logic             push_req;
    logic             do_push;
    logic             do_pop;
    logic             drop;
    logic             empty;
    logic             full;
    logic [CT_W-1:0]  head;

    // Push/pop qualification; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        push_req = ct_valid_i & ~valid_q;
        empty    = (count_q == CNT_W'(0));
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop_i & ~empty & ~clear_i;
        do_push  = push_req & (~full | do_pop) & ~clear_i;
        drop     = push_req & full & ~pop_i & ~clear_i;
    end

    // Pointer, occupancy and sticky overflow state; clear overrides everything but valid_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= ct_valid_i;
            if (clear_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (do_push && !do_pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (do_pop && !do_push) begin
                    count_q <= count_q - CNT_W'(1);
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= ct_i;
        end
    end

    always_comb begin
        head       = mem[rd_ptr_q];
        rd_data_o  = empty ? 32'h0 : head[{rd_word_sel_i, 5'b0} +: 32];
        count_o    = count_q;
        empty_o    = empty;
        full_o     = full;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_aes_ct_result_fifo.sv
// Bench for aes_ct_result_fifo: the driver updates a queue model of expected entries as it
// issues stimulus; an independent monitor compares every cycle's outputs against it.
module tb_aes_ct_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [127:0]     ct = '0;
    logic             ct_valid = 1'b0;
    logic             clear = 1'b0;
    logic             pop = 1'b0;
    logic [1:0]       sel = 2'd0;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;

    logic [127:0]     m_q[$];
    logic             m_vq = 1'b0;
    logic             m_ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_ct_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ct_i          (ct),
        .ct_valid_i    (ct_valid),
        .clear_i       (clear),
        .pop_i         (pop),
        .rd_word_sel_i (sel),
        .rd_data_o     (rd_data),
        .count_o       (count),
        .empty_o       (empty),
        .full_o        (full),
        .overflow_o    (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has applied the edge's effect to the model.
    always @(posedge clk) begin
        logic [127:0] h;
        logic [31:0]  e;
        #3;
        e = 32'h0;
        if (m_q.size() > 0) begin
            h = m_q[0];
            e = h[{sel, 5'b0} +: 32];
        end
        chk("count",    32'(count),    32'(m_q.size()));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rd_data",  rd_data,       e);
    end

    // One clock of stimulus; the model applies what the DUT should do on that edge.
    task automatic step(input logic v, input logic [127:0] ct_v, input logic p,
                        input logic c, input logic [1:0] s);
        int   pre;
        logic edge_seen;
        @(negedge clk);
        rst_n    = 1'b1;
        ct_valid = v;
        ct       = ct_v;
        pop      = p;
        clear    = c;
        sel      = s;
        @(posedge clk);
        #1;
        pre       = m_q.size();
        edge_seen = v & ~m_vq;
        m_vq      = v;
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (p && pre > 0) void'(m_q.pop_front());
            if (edge_seen) begin
                if (pre < DEPTH || (p && pre > 0)) m_q.push_back(ct_v);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // Asserts reset; the next step releases it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_vq  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse(input logic [127:0] v);
        step(1'b1, v, 1'b0, 1'b0, 2'd0);
        step(1'b0, v, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic [127:0] k;
        k = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 2'd0);

        // Single capture from a 5-cycle level, reading all four words.
        for (int i = 0; i < 5; i++) step(1'b1, k, 1'b0, 1'b0, 2'(i));
        step(1'b0, k, 1'b0, 1'b0, 2'd3);
        step(1'b0, k, 1'b1, 1'b0, 2'd0);

        // Fill past capacity, then drain.
        for (int i = 1; i <= 5; i++) pulse(128'(i));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 2'(i));
        step(1'b0, '0, 1'b0, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b1, 2'd0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) pulse(128'(i));
        step(1'b1, 128'd9, 1'b1, 1'b0, 2'd0);
        step(1'b0, 128'd9, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 2'd0);

        // Empty edge cases.
        step(1'b0, '0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 128'd7, 1'b1, 1'b0, 2'd0);
        step(1'b0, 128'd7, 1'b0, 1'b0, 2'd0);
        step(1'b0, 128'd7, 1'b1, 1'b0, 2'd0);

        // Clear while the level is still high must not re-capture.
        pulse(128'hA1);
        pulse(128'hA2);
        step(1'b1, 128'hA3, 1'b0, 1'b0, 2'd0);
        step(1'b1, 128'hA3, 1'b0, 1'b1, 2'd0);
        step(1'b1, 128'hA3, 1'b0, 1'b0, 2'd0);
        step(1'b0, 128'hA3, 1'b0, 1'b0, 2'd0);

        // Push/pop pairs across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, {32'(i + 1), 32'hF00D, 32'(i * 3), 32'(100 + i)}, 1'b0, 1'b0, 2'(i));
            step(1'b0, '0, 1'b1, 1'b0, 2'(i + 1));
        end

        // Reset mid-operation with the level held high across release.
        pulse(128'hB1);
        pulse(128'hB2);
        for (int i = 1; i <= 3; i++) pulse(128'hB2 + 128'(i));
        step(1'b1, 128'hC0FFEE, 1'b0, 1'b0, 2'd0);
        do_reset();
        step(1'b1, 128'hC0FFEE, 1'b0, 1'b0, 2'd0);
        step(1'b1, 128'hC0FFEE, 1'b0, 1'b0, 2'd1);
        step(1'b0, '0, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b0, 2'd0);

        @(posedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
